// File: rtl/phys_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// phys_mem_arbiter_if
// Bundles every handshake and bus signal between phys_mem_arbiter, the two
// L1 line requesters (I$ fill, D$ fill/writeback) and the Physical RAM port.
//
// Modports
//   master : the arbiter itself. It drives the RAM port and the requester
//            status signals, and reads the requests and RAM responses.
//   slave  : the environment (both caches plus the RAM). It drives requests
//            and RAM responses and reads everything the arbiter produces.
//
// Signal groups
//   ic_req/ic_addr                  -> I$ line read request
//   ic_beat/ic_done/ic_err          <- I$ beat strobe, completion, reject flag
//   dc_req/dc_rw/dc_addr/dc_wr_data -> D$ line request and writeback data
//   dc_beat/dc_done/dc_err          <- D$ beat strobe, completion, reject flag
//   beat_idx/rd_data                <- shared beat index and read data
//   mem_req/mem_rw/mem_addr/mem_wr_data <- RAM command
//   mem_rd_data/mem_ready           -> RAM response
//
// Handshake: a requester raises x_req and holds it, with its address and
// direction stable, until the one-cycle x_done pulse. A RAM beat completes in
// every cycle where mem_req=1 and mem_ready=1; while mem_ready=0 the command
// (mem_req/mem_rw/mem_addr/mem_wr_data) is held unchanged.
// ---------------------------------------------------------------------------
interface phys_mem_arbiter_if #(
    parameter int CL_LEN = 32
);
    localparam int IDX_W = $clog2(CL_LEN / 4);

    logic             ic_req;
    logic [31:0]      ic_addr;
    logic             ic_beat;
    logic             ic_done;
    logic             ic_err;

    logic             dc_req;
    logic             dc_rw;
    logic [31:0]      dc_addr;
    logic [31:0]      dc_wr_data;
    logic             dc_beat;
    logic             dc_done;
    logic             dc_err;

    logic [IDX_W-1:0] beat_idx;
    logic [31:0]      rd_data;

    logic             mem_req;
    logic             mem_rw;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wr_data;
    logic [31:0]      mem_rd_data;
    logic             mem_ready;

    modport master (
        input  ic_req, ic_addr,
        input  dc_req, dc_rw, dc_addr, dc_wr_data,
        input  mem_rd_data, mem_ready,
        output ic_beat, ic_done, ic_err,
        output dc_beat, dc_done, dc_err,
        output beat_idx, rd_data,
        output mem_req, mem_rw, mem_addr, mem_wr_data
    );

    modport slave (
        output ic_req, ic_addr,
        output dc_req, dc_rw, dc_addr, dc_wr_data,
        output mem_rd_data, mem_ready,
        input  ic_beat, ic_done, ic_err,
        input  dc_beat, dc_done, dc_err,
        input  beat_idx, rd_data,
        input  mem_req, mem_rw, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/phys_mem_arbiter.sv
// ---------------------------------------------------------------------------
// phys_mem_arbiter
// Shares the single Physical RAM port between the L1 I$ line-fill requester
// and the L1 D$ fill/writeback requester. Each grant is one cache-line burst
// of CL_LEN/4 32-bit beats. When both requesters are pending in IDLE the one
// that was not granted last wins (round robin).
//
// Optional feature macro: ARB_ADDR_CHK_EN
//   defined     : a line whose bytes are not all inside PHYS_LO..PHYS_HI is
//                 rejected (REJECT state, x_done + x_err for one cycle).
//   not defined : no range check, ic_err/dc_err tied 0, every request bursts.
//
// Ports
//   clk_in    : clock
//   reset_in  : synchronous active-high reset; aborts any burst, no done pulse
//   bus       : phys_mem_arbiter_if.master (requesters + RAM port)
//   state_dbg : current FSM state encoding (debug observation)
//
// Timing: a request sampled in IDLE at edge N produces mem_req=1 after N.
// x_beat is the same-cycle decode of mem_ready during the granted burst;
// x_done/x_err/mem_req/mem_rw/beat_idx are registered.
// ---------------------------------------------------------------------------
module phys_mem_arbiter #(
    parameter int          CL_LEN     = 32,
    parameter logic [31:0] PHYS_LO    = 32'h0000_0000,
    parameter int          PHYS_DEPTH = 8192
) (
    input  logic                clk_in,
    input  logic                reset_in,
    phys_mem_arbiter_if.master  bus,
    output logic [2:0]          state_dbg
);
    localparam int          WPL       = CL_LEN / 4;
    localparam int          IDX_W     = $clog2(WPL);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(WPL - 1);
    localparam logic [31:0] LINE_MASK = ~(32'(CL_LEN) - 32'd1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BURST_IC = 3'd1,
        BURST_DC = 3'd2,
        DONE     = 3'd3
`ifdef ARB_ADDR_CHK_EN
        ,
        REJECT   = 3'd4
`endif
    } state_t;

    state_t           state;
    logic             last_grant_dc;   // 1 = D$ was granted most recently
    logic [31:0]      base;
    logic [IDX_W-1:0] beat_idx_q;
    logic             mem_req_q;
    logic             mem_rw_q;
    logic             ic_done_q;
    logic             dc_done_q;

    logic             grant_ic;
    logic             grant_dc;
    logic [31:0]      req_base;

    // Arbitration decode, only consumed while in IDLE.
    always_comb begin
        grant_ic = bus.ic_req && (!bus.dc_req || last_grant_dc);
        grant_dc = bus.dc_req && !grant_ic;
        req_base = (grant_ic ? bus.ic_addr : bus.dc_addr) & LINE_MASK;
    end

`ifdef ARB_ADDR_CHK_EN
    localparam logic [31:0] RANGE_LIMIT = 32'(PHYS_DEPTH - CL_LEN);

    logic        ic_err_q;
    logic        dc_err_q;
    logic [31:0] req_off;
    logic        in_range;

    // Offset from PHYS_LO in 32-bit modulo arithmetic: a base below PHYS_LO
    // wraps to a huge offset, so one compare covers both ends of the window.
    always_comb begin
        req_off  = req_base - PHYS_LO;
        in_range = (req_off <= RANGE_LIMIT);
    end
`endif

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state         <= IDLE;
            last_grant_dc <= 1'b1;
            base          <= 32'd0;
            beat_idx_q    <= '0;
            mem_req_q     <= 1'b0;
            mem_rw_q      <= 1'b0;
            ic_done_q     <= 1'b0;
            dc_done_q     <= 1'b0;
`ifdef ARB_ADDR_CHK_EN
            ic_err_q      <= 1'b0;
            dc_err_q      <= 1'b0;
`endif
        end else begin
            // Completion flags are single-cycle pulses.
            ic_done_q <= 1'b0;
            dc_done_q <= 1'b0;
`ifdef ARB_ADDR_CHK_EN
            ic_err_q  <= 1'b0;
            dc_err_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant_ic || grant_dc) begin
                        last_grant_dc <= grant_dc;
                        base          <= req_base;
                        beat_idx_q    <= '0;
`ifdef ARB_ADDR_CHK_EN
                        if (!in_range) begin
                            state     <= REJECT;
                            ic_done_q <= grant_ic;
                            dc_done_q <= grant_dc;
                            ic_err_q  <= grant_ic;
                            dc_err_q  <= grant_dc;
                        end else begin
                            state     <= grant_ic ? BURST_IC : BURST_DC;
                            mem_req_q <= 1'b1;
                            mem_rw_q  <= grant_dc && bus.dc_rw;
                        end
`else
                        state     <= grant_ic ? BURST_IC : BURST_DC;
                        mem_req_q <= 1'b1;
                        mem_rw_q  <= grant_dc && bus.dc_rw;
`endif
                    end
                end
                BURST_IC, BURST_DC: begin
                    // mem_ready=0 is a wait state: nothing changes.
                    if (bus.mem_ready) begin
                        if (beat_idx_q == LAST_BEAT) begin
                            state      <= DONE;
                            mem_req_q  <= 1'b0;
                            mem_rw_q   <= 1'b0;
                            beat_idx_q <= '0;
                            ic_done_q  <= (state == BURST_IC);
                            dc_done_q  <= (state == BURST_DC);
                        end else begin
                            beat_idx_q <= beat_idx_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
`ifdef ARB_ADDR_CHK_EN
                REJECT: begin
                    state <= IDLE;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ic_beat     = (state == BURST_IC) && bus.mem_ready;
    assign bus.dc_beat     = (state == BURST_DC) && bus.mem_ready;
    assign bus.ic_done     = ic_done_q;
    assign bus.dc_done     = dc_done_q;
`ifdef ARB_ADDR_CHK_EN
    assign bus.ic_err      = ic_err_q;
    assign bus.dc_err      = dc_err_q;
`else
    assign bus.ic_err      = 1'b0;
    assign bus.dc_err      = 1'b0;
`endif
    assign bus.beat_idx    = beat_idx_q;
    assign bus.rd_data     = bus.mem_rd_data;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_rw      = mem_rw_q;
    // Address is forced to 0 outside a burst so the RAM port is quiet.
    assign bus.mem_addr    = mem_req_q
                             ? (base + {{(30 - IDX_W){1'b0}}, beat_idx_q, 2'b00})
                             : 32'd0;
    assign bus.mem_wr_data = ((state == BURST_DC) && mem_rw_q) ? bus.dc_wr_data : 32'd0;
    assign state_dbg       = state;

endmodule

// File: tb/tb_phys_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_phys_mem_arbiter
// Directed bench for phys_mem_arbiter (CL_LEN=32, PHYS 0x0000..0x1FFF).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// after a further 1 unit so both registered and same-cycle values are seen.
// The RAM returns mem_addr ^ RD_XOR while mem_req is high, else 0.
// ---------------------------------------------------------------------------
module tb_phys_mem_arbiter;
    localparam logic [31:0] RD_XOR = 32'h5A5A_5A5A;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic [2:0] state_dbg;
    int         checks   = 0;
    int         failures = 0;

    phys_mem_arbiter_if #(.CL_LEN(32)) bus ();

    phys_mem_arbiter #(
        .CL_LEN    (32),
        .PHYS_LO   (32'h0000_0000),
        .PHYS_DEPTH(8192)
    ) dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    always #5 clk_in = ~clk_in;

    assign bus.mem_rd_data = bus.mem_req ? (bus.mem_addr ^ RD_XOR) : 32'd0;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        reset_in       = 1'b1;
        bus.ic_req     = 1'b0;
        bus.ic_addr    = 32'd0;
        bus.dc_req     = 1'b0;
        bus.dc_rw      = 1'b0;
        bus.dc_addr    = 32'd0;
        bus.dc_wr_data = 32'd0;
        bus.mem_ready  = 1'b0;
        step();
        step();
        #1;
        checks++;
        if ({bus.ic_beat, bus.ic_done, bus.ic_err, bus.dc_beat, bus.dc_done,
             bus.dc_err, bus.mem_req, bus.mem_rw} !== 8'h00) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00000000",
                     {bus.ic_beat, bus.ic_done, bus.ic_err, bus.dc_beat, bus.dc_done,
                      bus.dc_err, bus.mem_req, bus.mem_rw});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wr_data, bus.rd_data} !== 96'd0) begin
            failures++;
            $display("FAIL reset_buses addr=%h wdata=%h rdata=%h want=0",
                     bus.mem_addr, bus.mem_wr_data, bus.rd_data);
        end
        checks++;
        if ({bus.beat_idx, state_dbg} !== 6'd0) begin
            failures++;
            $display("FAIL reset_state beat_idx=%0d state=%0d want=0", bus.beat_idx, state_dbg);
        end
        // First request after reset: D$ read of line 0x40.
        reset_in      = 1'b0;
        bus.dc_req    = 1'b1;
        bus.dc_addr   = 32'h0000_0044;
        bus.mem_ready = 1'b1;
        step();
        checks++;
        if ({bus.mem_req, bus.dc_beat, bus.ic_beat} !== 3'b110 || bus.mem_addr !== 32'h40) begin
            failures++;
            $display("FAIL reset_first_grant req/dcb/icb=%b addr=%h want=110 00000040",
                     {bus.mem_req, bus.dc_beat, bus.ic_beat}, bus.mem_addr);
        end
        for (int b = 1; b < 8; b++) step();
        step();
        checks++;
        if ({bus.dc_done, bus.dc_err, bus.mem_req} !== 3'b100) begin
            failures++;
            $display("FAIL reset_first_done done/err/req=%b want=100",
                     {bus.dc_done, bus.dc_err, bus.mem_req});
        end
        bus.dc_req = 1'b0;
        step();
        checks++;
        if (bus.dc_done !== 1'b0 || state_dbg !== 3'd0) begin
            failures++;
            $display("FAIL reset_back_idle done=%b state=%0d want=0 0", bus.dc_done, state_dbg);
        end
    endtask

    task automatic test_ic_read();
        logic [31:0] exp_addr;
        bus.ic_req    = 1'b1;
        bus.ic_addr   = 32'h0000_0104;
        bus.mem_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            step();
            exp_addr = 32'h100 + 32'(4 * b);
            checks++;
            if ({bus.mem_req, bus.mem_rw, bus.ic_beat, bus.dc_beat, bus.ic_done} !== 5'b10100) begin
                failures++;
                $display("FAIL ic_ctl beat %0d got=%b want=10100", b,
                         {bus.mem_req, bus.mem_rw, bus.ic_beat, bus.dc_beat, bus.ic_done});
            end
            checks++;
            if (bus.mem_addr !== exp_addr || bus.beat_idx !== 3'(b)) begin
                failures++;
                $display("FAIL ic_addr beat %0d addr=%h idx=%0d want=%h %0d",
                         b, bus.mem_addr, bus.beat_idx, exp_addr, b);
            end
            checks++;
            if (bus.rd_data !== (exp_addr ^ RD_XOR)) begin
                failures++;
                $display("FAIL ic_rd_data beat %0d got=%h want=%h", b, bus.rd_data, exp_addr ^ RD_XOR);
            end
        end
        step();
        checks++;
        if ({bus.ic_done, bus.ic_err, bus.mem_req, bus.ic_beat, bus.dc_done} !== 5'b10000) begin
            failures++;
            $display("FAIL ic_done got=%b want=10000",
                     {bus.ic_done, bus.ic_err, bus.mem_req, bus.ic_beat, bus.dc_done});
        end
        bus.ic_req = 1'b0;
        step();
        checks++;
        if ({bus.ic_done, bus.mem_req} !== 2'b00) begin
            failures++;
            $display("FAIL ic_after_done done/req=%b want=00", {bus.ic_done, bus.mem_req});
        end
    endtask

    task automatic test_contention();
        logic exp_ic;
        reset_in = 1'b1;
        step();
        reset_in      = 1'b0;
        bus.ic_req    = 1'b1;
        bus.ic_addr   = 32'h0000_0200;
        bus.dc_req    = 1'b1;
        bus.dc_rw     = 1'b0;
        bus.dc_addr   = 32'h0000_0300;
        bus.mem_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_ic = (g % 2 == 0);
            step();
            checks++;
            if ({bus.ic_beat, bus.dc_beat} !== (exp_ic ? 2'b10 : 2'b01) ||
                bus.mem_addr !== (exp_ic ? 32'h200 : 32'h300)) begin
                failures++;
                $display("FAIL contention_grant %0d beats=%b addr=%h want_ic=%b",
                         g, {bus.ic_beat, bus.dc_beat}, bus.mem_addr, exp_ic);
            end
            for (int b = 1; b < 8; b++) step();
            step();
            checks++;
            if ({bus.ic_done, bus.dc_done} !== (exp_ic ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL contention_done %0d got=%b want_ic=%b",
                         g, {bus.ic_done, bus.dc_done}, exp_ic);
            end
            step();
            checks++;
            if (bus.mem_req !== 1'b0 || state_dbg !== 3'd0) begin
                failures++;
                $display("FAIL contention_idle %0d req=%b state=%0d want=0 0", g, bus.mem_req, state_dbg);
            end
        end
        bus.ic_req = 1'b0;
        bus.dc_req = 1'b0;
        step();
    endtask

    task automatic test_dc_write_stall();
        logic [31:0] exp_addr;
        bus.dc_req    = 1'b1;
        bus.dc_rw     = 1'b1;
        bus.dc_addr   = 32'h0000_1000;
        bus.mem_ready = 1'b0;
        step();
        for (int c = 0; c < 16; c++) begin
            bus.mem_ready  = (c % 2 == 1);
            bus.dc_wr_data = 32'hD00D_0000 + 32'(c);
            #1;
            exp_addr = 32'h1000 + 32'(4 * (c / 2));
            checks++;
            if ({bus.mem_req, bus.mem_rw, bus.dc_beat, bus.ic_beat} !== {2'b11, (c % 2 == 1), 1'b0}) begin
                failures++;
                $display("FAIL dcw_ctl cycle %0d req/rw/dcb/icb=%b", c,
                         {bus.mem_req, bus.mem_rw, bus.dc_beat, bus.ic_beat});
            end
            checks++;
            if (bus.mem_addr !== exp_addr || bus.beat_idx !== 3'(c / 2)) begin
                failures++;
                $display("FAIL dcw_addr cycle %0d addr=%h idx=%0d want=%h %0d",
                         c, bus.mem_addr, bus.beat_idx, exp_addr, c / 2);
            end
            checks++;
            if (bus.mem_wr_data !== 32'hD00D_0000 + 32'(c)) begin
                failures++;
                $display("FAIL dcw_wdata cycle %0d got=%h want=%h",
                         c, bus.mem_wr_data, 32'hD00D_0000 + 32'(c));
            end
            step();
        end
        checks++;
        if ({bus.dc_done, bus.dc_err, bus.mem_req, bus.mem_rw} !== 4'b1000 || bus.mem_wr_data !== 32'd0) begin
            failures++;
            $display("FAIL dcw_done done/err/req/rw=%b wdata=%h want=1000 0",
                     {bus.dc_done, bus.dc_err, bus.mem_req, bus.mem_rw}, bus.mem_wr_data);
        end
        bus.dc_req    = 1'b0;
        bus.dc_rw     = 1'b0;
        bus.mem_ready = 1'b1;
        step();
    endtask

    task automatic test_out_of_range();
        logic [31:0] addrs [2];
        addrs[0] = 32'h0300_0000;
        addrs[1] = 32'h0000_2000;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.dc_req  = 1'b1;
            bus.dc_rw   = 1'b0;
            bus.dc_addr = addrs[i];
            step();
`ifdef ARB_ADDR_CHK_EN
            checks++;
            if ({bus.mem_req, bus.dc_done, bus.dc_err, bus.dc_beat} !== 4'b0110) begin
                failures++;
                $display("FAIL oor_reject %h req/done/err/beat=%b want=0110",
                         addrs[i], {bus.mem_req, bus.dc_done, bus.dc_err, bus.dc_beat});
            end
            bus.dc_req = 1'b0;
            step();
            checks++;
            if ({bus.dc_done, bus.dc_err, bus.mem_req} !== 3'b000) begin
                failures++;
                $display("FAIL oor_clear %h done/err/req=%b want=000",
                         addrs[i], {bus.dc_done, bus.dc_err, bus.mem_req});
            end
`else
            checks++;
            if ({bus.mem_req, bus.dc_beat} !== 2'b11 || bus.mem_addr !== addrs[i]) begin
                failures++;
                $display("FAIL oor_burst %h req/beat=%b addr=%h want=11 %h",
                         addrs[i], {bus.mem_req, bus.dc_beat}, bus.mem_addr, addrs[i]);
            end
            for (int b = 1; b < 8; b++) step();
            step();
            checks++;
            if ({bus.dc_done, bus.dc_err} !== 2'b10) begin
                failures++;
                $display("FAIL oor_done %h done/err=%b want=10", addrs[i], {bus.dc_done, bus.dc_err});
            end
            bus.dc_req = 1'b0;
            step();
`endif
        end
        // Last line of RAM is always legal.
        bus.dc_req  = 1'b1;
        bus.dc_addr = 32'h0000_1FE4;
        step();
        checks++;
        if ({bus.mem_req, bus.dc_beat} !== 2'b11 || bus.mem_addr !== 32'h1FE0) begin
            failures++;
            $display("FAIL edge_first req/beat=%b addr=%h want=11 00001fe0",
                     {bus.mem_req, bus.dc_beat}, bus.mem_addr);
        end
        for (int b = 1; b < 8; b++) step();
        checks++;
        if (bus.mem_addr !== 32'h1FFC) begin
            failures++;
            $display("FAIL edge_last addr=%h want=00001ffc", bus.mem_addr);
        end
        step();
        checks++;
        if ({bus.dc_done, bus.dc_err} !== 2'b10) begin
            failures++;
            $display("FAIL edge_done done/err=%b want=10", {bus.dc_done, bus.dc_err});
        end
        bus.dc_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_burst();
        bus.ic_req    = 1'b1;
        bus.ic_addr   = 32'h0000_0244;
        bus.mem_ready = 1'b1;
        for (int b = 0; b < 4; b++) step();
        checks++;
        if (bus.beat_idx !== 3'd3 || bus.mem_addr !== 32'h24C) begin
            failures++;
            $display("FAIL midrst_beat3 idx=%0d addr=%h want=3 0000024c", bus.beat_idx, bus.mem_addr);
        end
        reset_in = 1'b1;
        step();
        checks++;
        if ({bus.mem_req, bus.ic_done, bus.ic_beat} !== 3'b000 || bus.beat_idx !== 3'd0) begin
            failures++;
            $display("FAIL midrst_abort req/done/beat=%b idx=%0d want=000 0",
                     {bus.mem_req, bus.ic_done, bus.ic_beat}, bus.beat_idx);
        end
        reset_in = 1'b0;
        step();
        checks++;
        if ({bus.mem_req, bus.ic_beat} !== 2'b11 || bus.beat_idx !== 3'd0 || bus.mem_addr !== 32'h240) begin
            failures++;
            $display("FAIL midrst_restart req/beat=%b idx=%0d addr=%h want=11 0 00000240",
                     {bus.mem_req, bus.ic_beat}, bus.beat_idx, bus.mem_addr);
        end
        for (int b = 1; b < 8; b++) step();
        step();
        checks++;
        if (bus.ic_done !== 1'b1) begin
            failures++;
            $display("FAIL midrst_done got=%b want=1", bus.ic_done);
        end
        bus.ic_req = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ic_read();
        test_contention();
        test_dc_write_stall();
        test_out_of_range();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
